run_det_arbiter: RTL

- Shares one consecutive-ones run detector among NCH serial requesters.
- Keeps a run-count context for each channel.
- A round-robin arbiter accepts at most one channel's bit per cycle and updates that channel's context.
- Reports detections tagged with the channel ID, plus a global saturating detection counter. Sits between the serial input channels and the status/interrupt logic.

---
 rtl/run_det_if.sv | 26 ++
 rtl/run_det_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/run_det_if.sv
// Bundles the requester-side and status-side signals of run_det_arbiter.
//   enable, clr_cnt, req, bit_in : driven by the master (requesters/control)
//   gnt, det_valid, det_ch, det_cnt : driven by the slave (the arbiter)
interface run_det_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IDW = 2
);
  logic           enable;
  logic           clr_cnt;
  logic [NCH-1:0] req;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] gnt;
  logic           det_valid;
  logic [IDW-1:0] det_ch;
  logic [7:0]     det_cnt;

  modport master (
    output enable, clr_cnt, req, bit_in,
    input  gnt, det_valid, det_ch, det_cnt
  );

  modport slave (
    input  enable, clr_cnt, req, bit_in,
    output gnt, det_valid, det_ch, det_cnt
  );
endinterface

// File: rtl/run_det_arbiter.sv
// Shared consecutive-ones run detector for NCH serial requesters.
// A round-robin arbiter accepts one channel's bit per cycle and advances that
// channel's run-count context; a run of RUN_LEN ones raises a tagged detection.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   bus_io : slave side of run_det_if (enable, clr_cnt, req, bit_in in;
//            gnt, det_valid, det_ch, det_cnt out, all registered)
module run_det_arbiter #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned RUN_LEN = 3
) (
  input  logic    clk,
  input  logic    rst,
  run_det_if.slave bus_io
);
  localparam int unsigned CW = $clog2(RUN_LEN) + 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] gnt_q, gnt_d;
  logic           det_valid_q, det_valid_d;
  logic [IDW-1:0] det_ch_q, det_ch_d;
  logic [7:0]     det_cnt_q, det_cnt_d;

  logic [NCH-1:0] elig;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;
  logic           hit;

  // A channel granted last cycle is masked so its stale bit is not consumed twice.
  assign elig = bus_io.req & ~gnt_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    if (bus_io.enable) begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        cand = IDW'((32'(ptr_q) + k) % NCH);
        if (!pick_valid && elig[cand]) begin
          pick_valid = 1'b1;
          pick_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    det_valid_d = 1'b0;
    det_ch_d    = '0;
    hit         = 1'b0;

    if (pick_valid) begin
      ptr_d           = pick_idx;
      gnt_d[pick_idx] = 1'b1;
      if (!bus_io.bit_in[pick_idx]) begin
        cnt_d[pick_idx] = '0;
      end else if (cnt_q[pick_idx] == CW'(RUN_LEN - 1)) begin
        // Non-overlapping: the run restarts from zero after a detection.
        cnt_d[pick_idx] = '0;
        hit             = 1'b1;
      end else begin
        cnt_d[pick_idx] = cnt_q[pick_idx] + CW'(1);
      end
    end

    if (hit) begin
      det_valid_d = 1'b1;
      det_ch_d    = pick_idx;
    end

    // Clear wins over a same-cycle detection.
    if (bus_io.clr_cnt) begin
      det_cnt_d = '0;
    end else if (hit && (det_cnt_q != 8'hFF)) begin
      det_cnt_d = det_cnt_q + 8'd1;
    end else begin
      det_cnt_d = det_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= IDW'(NCH - 1);
      gnt_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_cnt_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      det_cnt_q   <= det_cnt_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.det_valid = det_valid_q;
  assign bus_io.det_ch    = det_ch_q;
  assign bus_io.det_cnt   = det_cnt_q;

endmodule
